uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Packet-granular round-robin arbiter that shares one UART transmitter between N_REQ AXI-Stream-style byte sources. It sits between the requesters (command responder, status reporter, debug logger, ...) and the transmitter's tx_data/tx_data_valid/tx_data_ready input. A grant is held from the first beat of a packet to its last beat. An optional source-ID header byte is inserted ahead of each packet, and a watchdog reclaims the channel from a requester that stalls mid-packet.

## Interface
- N_REQ, 4: number of requesters, 2..8
- DATA_W, 8: byte width; must exceed ID_W
- ID_W, $clog2(N_REQ): requester index width (localparam)
- HDR_EN, 1: 1 = emit a header byte before each packet
- HDR_TAG, 8'hA0: header upper bits; header = {HDR_TAG[DATA_W-1:ID_W], id}
- TIMEOUT, 1024: idle-cycle limit within a packet; 0 disables the watchdog
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s_tdata  in  N_REQ*DATA_W  requester bytes; slice i belongs to requester i
- s_tvalid  in  N_REQ  per-requester valid
- s_tlast  in  N_REQ  per-requester end-of-packet
- s_tready  out  N_REQ  per-requester ready; only the granted bit can be 1
- m_tdata  out  DATA_W  byte to transmitter
- m_tvalid  out  1  byte valid to transmitter
- m_tready  in  1  transmitter ready (high while the transmitter is idle)
- m_tlast  out  1  last byte of the current packet
- grant_id  out  ID_W  current or last granted requester
- busy  out  1  a packet is in progress (state is not ARB)
- err_timeout  out  1  one-cycle pulse when the watchdog fires

## Operation
- FSM states: ARB, HDR, PAYLOAD.
- ARB
  - All s_tready = 0, m_tvalid = 0.
  - If any s_tvalid is high, pick the first requester with s_tvalid set, searching from rr_ptr upward with wrap.
  - Register the winner into grant_id.
  - Go to HDR if HDR_EN = 1, else to PAYLOAD.
  - The choice is fixed on entry to HDR/PAYLOAD; later changes in s_tvalid do not affect it.
- HDR
  - m_tdata = header byte, m_tvalid = 1, m_tlast = 0, all s_tready = 0.
  - On m_tready = 1, go to PAYLOAD.
- PAYLOAD
  - Pass-through from the granted requester: m_tdata = s_tdata[grant], m_tvalid = s_tvalid[grant], m_tlast = s_tlast[grant], s_tready[grant] = m_tready.
  - A transfer is a cycle where m_tvalid = 1 and m_tready = 1.
  - A transfer with m_tlast = 1 returns the FSM to ARB and sets rr_ptr = grant_id+1 mod N_REQ.
- Watchdog (TIMEOUT > 0)
  - Counter cleared in ARB and HDR, and on every transfer.
  - Counter increments only on PAYLOAD cycles where s_tvalid[grant] = 0. Cycles stalled by the transmitter (m_tready = 0) do not count.
  - When the count reaches TIMEOUT-1, the FSM goes to ARB, err_timeout pulses for one cycle, and rr_ptr advances past the offender.
  - No synthetic last byte is sent on timeout.
- Fairness: after a packet from requester k completes, every other requester that is continuously valid is served before k again.
- grant_id holds its last value while in ARB.

## Timing
- Reset values:
  - State ARB, rr_ptr = 0, grant_id = 0, busy = 0, err_timeout = 0, watchdog counter = 0.
  - Outputs during reset: m_tvalid = 0, m_tdata = 0, m_tlast = 0, s_tready = 0.
- Arbitration latency: one cycle. s_tvalid rising in cycle t gives the header (or first payload byte) on m_tdata in cycle t+1.
- Back-to-back packets insert exactly one ARB cycle between the last byte of one packet and the start of the next.
- m_tdata/m_tvalid/m_tlast/s_tready are combinational from the registered state and grant in PAYLOAD. There is no added latency per byte.
- Simultaneous last-byte transfer and watchdog expiry cannot occur, since a transfer clears the counter; the last byte wins.
- Reset mid-packet drops the grant immediately, with no residual transfer.
- A requester that asserts s_tvalid and then deasserts it before being granted is legal; ARB then picks the next requester that is still valid.

## Structure
- Shared package uart_pkg holds: FSM state encodings (ARB/HDR/PAYLOAD), the default HDR_TAG constant, and a header-byte build function.
- One natural sub-module: rr_arbiter, a combinational round-robin priority encoder with inputs req and ptr and outputs grant_idx and any_req. It is reusable for other shared resources.
- The watchdog counter is inline, with width $clog2(TIMEOUT+1).

## Test plan
- Single source: N_REQ = 4, HDR_EN = 1, requester 2 sends {0x11, 0x22 (last)} with m_tready always 1 -> m_tdata sequence 0xA2, 0x11, 0x22; m_tlast only on 0x22; busy high for 3 cycles.
- Contention: all four requesters continuously valid with 2-byte packets -> packet order 0, 1, 2, 3, 0; each packet preceded by its header 0xA0..0xA3; one ARB cycle between packets.
- Backpressure: m_tready toggles 1 cycle on / 9 cycles off during a 4-byte packet -> no byte lost or duplicated, no err_timeout with TIMEOUT = 4.
- Watchdog: TIMEOUT = 8, requester 1 sends one non-last byte then drops s_tvalid -> err_timeout pulses exactly 8 cycles after its last transfer; a waiting requester 3 is granted the next cycle.
- HDR_EN = 0 pass-through: requester 0 sends 0x55 (last) -> m_tdata 0x55 one cycle after s_tvalid rises; s_tready[0] equals m_tready.
- Reset mid-packet: assert rst during a byte of requester 3's payload -> all outputs zero immediately; after release, arbitration restarts from rr_ptr = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, default header tag and header-byte builder for the UART transmit arbiter
package uart_pkg;
  typedef enum logic [1:0] {ARB, HDR, PAYLOAD} state_e;
  localparam logic [7:0] HDR_TAG_DEF = 8'hA0;
  function automatic logic [31:0] hdr_byte(input logic [31:0] tag, input logic [31:0] id, input int id_w);
    logic [31:0] mask;
    mask = (32'd1 << id_w) - 32'd1;
    return (tag & ~mask) | (id & mask);
  endfunction
endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin priority encoder, first set req at or above ptr with wrap
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);
  logic [IW-1:0] j;
  always_comb begin
    grant_idx = '0;
    j = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = IW'((int'(ptr) + i) % N);
      if (req[j]) grant_idx = j;
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART transmitter, with optional ID header and stall watchdog
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = 8,
  parameter int HDR_EN = 1,
  parameter logic [DATA_W-1:0] HDR_TAG = DATA_W'(HDR_TAG_DEF),
  parameter int TIMEOUT = 1024,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] s_tdata,
  input  logic [N_REQ-1:0]        s_tvalid,
  input  logic [N_REQ-1:0]        s_tlast,
  output logic [N_REQ-1:0]        s_tready,
  output logic [DATA_W-1:0]       m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic                    err_timeout
);
  localparam int CW = $clog2(TIMEOUT + 1) > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_e state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d, ptr_q, ptr_d, arb_idx, next_ptr;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] s_bytes [N_REQ];
  logic any_req, sel_valid, sel_last, xfer, timeout;

  for (genvar g = 0; g < N_REQ; g++) begin : g_split
    assign s_bytes[g] = s_tdata[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req(s_tvalid), .ptr(ptr_q), .grant_idx(arb_idx), .any_req(any_req)
  );

  assign sel_valid = s_tvalid[grant_q];
  assign sel_last  = s_tlast[grant_q];
  assign xfer      = state_q == PAYLOAD && sel_valid && m_tready;
  // Only requester-side idling counts; a valid byte held off by the transmitter is not a stall
  assign timeout   = TIMEOUT > 0 && state_q == PAYLOAD && !sel_valid && cnt_q == TMAX;
  assign next_ptr  = grant_q == ID_W'(N_REQ - 1) ? '0 : grant_q + 1'b1;
  assign cnt_d     = (state_q != PAYLOAD || xfer || timeout) ? '0 : cnt_q + CW'(!sel_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      ARB: if (any_req) begin
        grant_d = arb_idx;
        state_d = HDR_EN != 0 ? HDR : PAYLOAD;
      end
      HDR: state_d = m_tready ? PAYLOAD : HDR;
      default: if ((xfer && sel_last) || timeout) begin
        state_d = ARB;
        ptr_d   = next_ptr;
      end
    endcase
  end

  always_comb begin
    m_tvalid    = state_q == HDR || (state_q == PAYLOAD && sel_valid);
    m_tdata     = state_q == HDR ? DATA_W'(hdr_byte(32'(HDR_TAG), 32'(grant_q), ID_W))
                : state_q == PAYLOAD ? s_bytes[grant_q] : '0;
    m_tlast     = state_q == PAYLOAD && sel_last;
    s_tready    = state_q == PAYLOAD ? N_REQ'(m_tready) << grant_q : '0;
    busy        = state_q != ARB;
    err_timeout = timeout;
    grant_id    = grant_q;
  end
endmodule
